// File: rtl/sine_lut_sweep_ctrl_pkg.sv
// Shared widths and sweep state encoding for the sine LUT sweep controller.
package sine_lut_sweep_ctrl_pkg;
  localparam int ACC_WIDTH_D   = 24;
  localparam int I_WIDTH_D     = 13;
  localparam int LUT_LATENCY_D = 2;
  localparam int CNT_WIDTH_D   = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_DWELL  = 3'd2,
    S_STEP   = 3'd3,
    S_DONE   = 3'd4
  } sweep_state_t;
endpackage

// File: rtl/sine_lut_sweep_ctrl_if.sv
// Sweep control bus: strobes and config in, LUT drive and sample tag out.
interface sine_lut_sweep_ctrl_if
  import sine_lut_sweep_ctrl_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_D,
  parameter int I_WIDTH   = I_WIDTH_D,
  parameter int CNT_WIDTH = CNT_WIDTH_D
);
  logic                 i_ce;
  logic                 i_start;
  logic                 i_abort;
  logic [ACC_WIDTH-1:0] i_ftw_start;
  logic [ACC_WIDTH-1:0] i_ftw_step;
  logic [CNT_WIDTH-1:0] i_num_steps;
  logic [CNT_WIDTH-1:0] i_settle;
  logic [CNT_WIDTH-1:0] i_dwell;
  logic [I_WIDTH-1:0]   o_phase;
  logic                 o_en;
  logic                 o_valid;
  logic [CNT_WIDTH-1:0] o_step_idx;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_ce, i_start, i_abort, i_ftw_start, i_ftw_step, i_num_steps, i_settle, i_dwell,
    input  o_phase, o_en, o_valid, o_step_idx, o_busy, o_done
  );

  modport slave (
    input  i_ce, i_start, i_abort, i_ftw_start, i_ftw_step, i_num_steps, i_settle, i_dwell,
    output o_phase, o_en, o_valid, o_step_idx, o_busy, o_done
  );
endinterface

// File: rtl/sine_lut_sweep_ctrl_nco_phase_acc.sv
// Phase accumulator: clears on sweep start, advances by the tuning word on each issued sample.
module sine_lut_sweep_ctrl_nco_phase_acc
  import sine_lut_sweep_ctrl_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_D,
  parameter int I_WIDTH   = I_WIDTH_D
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_adv,
  input  logic [ACC_WIDTH-1:0] i_ftw,
  output logic [I_WIDTH-1:0]   o_phase
);
  logic [ACC_WIDTH-1:0] acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   acc <= '0;
    else if (i_clr) acc <= '0;
    else if (i_adv) acc <= acc + i_ftw;
  end

  // The LUT samples the pre-add value, so the first sample of a sweep is phase 0.
  assign o_phase = acc[ACC_WIDTH-1 -: I_WIDTH];
endmodule

// File: rtl/sine_lut_sweep_ctrl.sv
// Frequency-sweep sequencer driving one sine_lut, with a tag pipe aligned to the LUT output.
module sine_lut_sweep_ctrl
  import sine_lut_sweep_ctrl_pkg::*;
#(
  parameter int ACC_WIDTH   = ACC_WIDTH_D,
  parameter int I_WIDTH     = I_WIDTH_D,
  parameter int LUT_LATENCY = LUT_LATENCY_D,
  parameter int CNT_WIDTH   = CNT_WIDTH_D
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  sine_lut_sweep_ctrl_if.slave  bus
);
  sweep_state_t         state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, idx, idx_nxt;
  logic [ACC_WIDTH-1:0] ftw, ftw_nxt, ftw_step_q;
  logic [CNT_WIDTH-1:0] num_steps_q, settle_q, dwell_q;
  logic [CNT_WIDTH-1:0] idx_last, dwell_last;
  logic                 load, en;

  logic [LUT_LATENCY-1:0]                vld_pipe;
  logic [LUT_LATENCY-1:0][CNT_WIDTH-1:0] idx_pipe;

  assign idx_last   = (num_steps_q == '0) ? '0 : num_steps_q - CNT_WIDTH'(1);
  assign dwell_last = (dwell_q == '0)     ? '0 : dwell_q - CNT_WIDTH'(1);
  assign en         = bus.i_ce && (state == S_SETTLE || state == S_DWELL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    ftw_nxt   = ftw;
    load      = 1'b0;
    case (state)
      S_IDLE: if (bus.i_start) begin
        load      = 1'b1;
        cnt_nxt   = '0;
        idx_nxt   = '0;
        ftw_nxt   = bus.i_ftw_start;
        state_nxt = (bus.i_settle == '0) ? S_DWELL : S_SETTLE;
      end
      S_SETTLE: if (bus.i_ce) begin
        if (cnt == settle_q - CNT_WIDTH'(1)) begin
          cnt_nxt   = '0;
          state_nxt = S_DWELL;
        end else cnt_nxt = cnt + CNT_WIDTH'(1);
      end
      S_DWELL: if (bus.i_ce) begin
        if (cnt == dwell_last) begin
          cnt_nxt   = '0;
          state_nxt = (idx == idx_last) ? S_DONE : S_STEP;
        end else cnt_nxt = cnt + CNT_WIDTH'(1);
      end
      S_STEP: begin
        ftw_nxt   = ftw + ftw_step_q;
        idx_nxt   = idx + CNT_WIDTH'(1);
        state_nxt = (settle_q == '0) ? S_DWELL : S_SETTLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort wins over everything, including a same-cycle start.
    if (bus.i_abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      load      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      ftw         <= '0;
      ftw_step_q  <= '0;
      num_steps_q <= '0;
      settle_q    <= '0;
      dwell_q     <= '0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      ftw <= ftw_nxt;
      if (load) begin
        ftw_step_q  <= bus.i_ftw_step;
        num_steps_q <= bus.i_num_steps;
        settle_q    <= bus.i_settle;
        dwell_q     <= bus.i_dwell;
      end
    end
  end

  sine_lut_sweep_ctrl_nco_phase_acc #(
    .ACC_WIDTH (ACC_WIDTH),
    .I_WIDTH   (I_WIDTH)
  ) u_nco (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (load),
    .i_adv   (en),
    .i_ftw   (ftw),
    .o_phase (bus.o_phase)
  );

  // Tag pipe mirrors the LUT latency; cleared on abort so nothing in flight surfaces.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else if (bus.i_abort) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= en && (state == S_DWELL);
      idx_pipe[0] <= idx;
      for (int i = LUT_LATENCY - 1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  assign bus.o_en       = en;
  assign bus.o_valid    = vld_pipe[LUT_LATENCY-1];
  assign bus.o_step_idx = idx_pipe[LUT_LATENCY-1];
  assign bus.o_busy     = (state != S_IDLE);
  assign bus.o_done     = (state == S_DONE);
endmodule

// File: tb/tb_sine_lut_sweep_ctrl.sv
// Bench for sine_lut_sweep_ctrl: directed table plus random sweeps against a sample-list model.
module tb_sine_lut_sweep_ctrl;
  localparam int AW  = 24;
  localparam int IW  = 13;
  localparam int LAT = 2;
  localparam int CW  = 16;

  typedef struct {
    logic [AW-1:0] ftw_start;
    logic [AW-1:0] ftw_step;
    logic [CW-1:0] n;
    logic [CW-1:0] settle;
    logic [CW-1:0] dwell;
    int            ce_mode;   // 0 always, 3 every third cycle, else random
    bit            noise;     // re-pulse start and scramble config while busy
    int            exp_valid;
  } vec_t;

  typedef struct {
    logic [IW-1:0] ph;
    bit            dw;
    int            idx;
  } smp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sine_lut_sweep_ctrl_if #(.ACC_WIDTH(AW), .I_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

  sine_lut_sweep_ctrl #(.ACC_WIDTH(AW), .I_WIDTH(IW), .LUT_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int   checks = 0;
  int   errors = 0;
  smp_t exp_q[$];
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Every issued LUT sample, in order: settle samples masked, dwell samples tagged.
  task automatic model(input vec_t v);
    logic [AW-1:0] acc, f;
    int n, d;
    exp_q.delete();
    n = (v.n == 0) ? 1 : int'(v.n);
    d = (v.dwell == 0) ? 1 : int'(v.dwell);
    acc = '0;
    for (int k = 0; k < n; k++) begin
      f = v.ftw_start + AW'(k) * v.ftw_step;
      for (int s = 0; s < int'(v.settle); s++) begin
        exp_q.push_back('{acc[AW-1 -: IW], 1'b0, k});
        acc = acc + f;
      end
      for (int s = 0; s < d; s++) begin
        exp_q.push_back('{acc[AW-1 -: IW], 1'b1, k});
        acc = acc + f;
      end
    end
  endtask

  task automatic drive_cfg(input vec_t v);
    bus.i_ftw_start = v.ftw_start;
    bus.i_ftw_step  = v.ftw_step;
    bus.i_num_steps = v.n;
    bus.i_settle    = v.settle;
    bus.i_dwell     = v.dwell;
  endtask

  task automatic run_sweep(input string nm, input vec_t v);
    int en_cyc[$];
    logic [IW-1:0] en_ph[$];
    int val_cyc[$];
    int val_idx[$];
    int done_cyc[$];
    int ev_cyc[$];
    int ev_idx[$];
    int cyc, tail, m;
    bit done_seen;
    model(v);
    @(posedge clk); #1;
    drive_cfg(v);
    bus.i_start = 1'b1;
    bus.i_ce    = 1'b1;
    cyc = 0; tail = 0; done_seen = 1'b0;
    @(negedge clk);
    while (cyc < 3000 && tail < LAT + 3) begin
      @(posedge clk); #1;
      bus.i_start = v.noise && !done_seen && ($urandom_range(0, 3) == 0);
      if (v.noise) begin
        bus.i_ftw_start = AW'($urandom);
        bus.i_ftw_step  = AW'($urandom);
        bus.i_num_steps = CW'($urandom_range(0, 9));
        bus.i_settle    = CW'($urandom_range(0, 9));
        bus.i_dwell     = CW'($urandom_range(0, 9));
      end
      case (v.ce_mode)
        0:       bus.i_ce = 1'b1;
        3:       bus.i_ce = (cyc % 3 == 2);
        default: bus.i_ce = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      cyc++;
      if (bus.o_en) begin
        chk({nm, "/en_without_ce"}, 32'(bus.i_ce), 32'd1);
        en_cyc.push_back(cyc);
        en_ph.push_back(bus.o_phase);
      end
      if (bus.o_valid) begin
        val_cyc.push_back(cyc);
        val_idx.push_back(int'(bus.o_step_idx));
      end
      if (bus.o_done) begin
        done_cyc.push_back(cyc);
        done_seen = 1'b1;
      end
      if (done_seen) tail++;
    end
    bus.i_start = 1'b0;
    bus.i_ce    = 1'b0;
    if (!done_seen) chk({nm, "/done_timeout"}, 32'd0, 32'd1);
    chk({nm, "/n_samples"}, 32'(en_cyc.size()), 32'(exp_q.size()));
    m = (en_cyc.size() < exp_q.size()) ? en_cyc.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s/phase%0d", nm, i), 32'(en_ph[i]), 32'(exp_q[i].ph));
      if (exp_q[i].dw) begin
        ev_cyc.push_back(en_cyc[i] + LAT);
        ev_idx.push_back(exp_q[i].idx);
      end
    end
    chk({nm, "/n_valid"}, 32'(val_cyc.size()), 32'(v.exp_valid));
    m = (val_cyc.size() < ev_cyc.size()) ? val_cyc.size() : ev_cyc.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s/valid_cyc%0d", nm, i), 32'(val_cyc[i]), 32'(ev_cyc[i]));
      chk($sformatf("%s/valid_idx%0d", nm, i), 32'(val_idx[i]), 32'(ev_idx[i]));
    end
    chk({nm, "/n_done"}, 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0 && en_cyc.size() > 0)
      chk({nm, "/done_cyc"}, 32'(done_cyc[0]), 32'(en_cyc[en_cyc.size()-1] + 1));
    chk({nm, "/busy_end"}, 32'(bus.o_busy), 32'd0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "/phase"}, 32'(bus.o_phase), 32'd0);
    chk({nm, "/en"}, 32'(bus.o_en), 32'd0);
    chk({nm, "/valid"}, 32'(bus.o_valid), 32'd0);
    chk({nm, "/step_idx"}, 32'(bus.o_step_idx), 32'd0);
    chk({nm, "/busy"}, 32'(bus.o_busy), 32'd0);
    chk({nm, "/done"}, 32'(bus.o_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int en_cnt, val_cnt, bad, guard;
    bus.i_ce = 1'b0; bus.i_start = 1'b0; bus.i_abort = 1'b0;
    bus.i_ftw_start = '0; bus.i_ftw_step = '0;
    bus.i_num_steps = '0; bus.i_settle = '0; bus.i_dwell = '0;

    vecs.push_back('{24'h010000, 24'h010000, 16'd3, 16'd2, 16'd4, 0, 1'b0, 12});
    vecs.push_back('{24'h010000, 24'h010000, 16'd3, 16'd2, 16'd4, 3, 1'b1, 12});
    vecs.push_back('{24'h123456, 24'h000777, 16'd0, 16'd0, 16'd0, 0, 1'b0, 1});
    vecs.push_back('{24'hFFFF00, 24'h000200, 16'd2, 16'd1, 16'd3, 0, 1'b0, 6});
    for (int r = 0; r < 6; r++) begin
      v.ftw_start = AW'($urandom);
      v.ftw_step  = AW'($urandom);
      v.n         = CW'($urandom_range(0, 4));
      v.settle    = CW'($urandom_range(0, 3));
      v.dwell     = CW'($urandom_range(0, 4));
      v.ce_mode   = 1;
      v.noise     = 1'b1;
      v.exp_valid = ((v.n == 0) ? 1 : int'(v.n)) * ((v.dwell == 0) ? 1 : int'(v.dwell));
      vecs.push_back(v);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) run_sweep($sformatf("vec%0d", i), vecs[i]);

    // Abort on the second dwell sample of step 1 (10th issued sample).
    v = vecs[0];
    @(posedge clk); #1;
    drive_cfg(v); bus.i_start = 1'b1; bus.i_ce = 1'b1;
    @(negedge clk);
    en_cnt = 0; val_cnt = 0; guard = 0;
    while (guard < 200) begin
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      bus.i_abort = (en_cnt == 9);
      @(negedge clk);
      guard++;
      if (bus.o_en) en_cnt++;
      if (bus.o_valid) val_cnt++;
      if (bus.i_abort) break;
    end
    chk("abort/en_at_abort", 32'(en_cnt), 32'd10);
    @(posedge clk); #1;
    bus.i_abort = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.o_busy || bus.o_en || bus.o_valid || bus.o_done) bad++;
    end
    chk("abort/quiet_after", 32'(bad), 32'd0);
    chk("abort/valid_before", 32'(val_cnt), 32'd4);
    bus.i_ce = 1'b0;
    run_sweep("restart_after_abort", vecs[0]);

    // Async reset in the middle of dwell.
    @(posedge clk); #1;
    drive_cfg(vecs[0]); bus.i_start = 1'b1; bus.i_ce = 1'b1;
    @(negedge clk);
    val_cnt = 0; guard = 0;
    while (val_cnt < 3 && guard < 200) begin
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      @(negedge clk);
      guard++;
      if (bus.o_valid) val_cnt++;
    end
    chk("rst_mid/reached_dwell", 32'(val_cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    @(posedge clk); #2 rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.o_busy || bus.o_done || bus.o_valid) bad++;
    end
    chk("rst_mid/quiet_after", 32'(bad), 32'd0);
    bus.i_ce = 1'b0;
    run_sweep("restart_after_rst", vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
